// File: rtl/hazard_unit.sv
// Hazard and stall controller for the 5-stage RV32I core: load-use bubbles,
// branch flushes, data-memory freeze with a timeout watchdog, and event counters.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   RUN      | normal operation
//   MEM_WAIT | a data-memory access is outstanding
//   ERROR    | memory timeout seen; frozen until reset
module hazard_unit #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic        useRS1_i,
  input  logic        useRS2_i,
  input  logic        ID_EX_MemRead_i,
  input  logic [4:0]  ID_EX_RDaddr_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic        hazard_o,
  output logic        PCWrite_o,
  output logic        IF_IDWrite_o,
  output logic        IF_Flush_o,
  output logic        freeze_o,
  output logic        mem_err_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            memstall, loaduse, in_err;
  logic            freeze_rule, flush_rule, lu_rule, to_err;

  assign memstall = dmem_req_i & ~dmem_ready_i;
  assign loaduse  = ID_EX_MemRead_i & (ID_EX_RDaddr_i != 5'd0) &
                    ((useRS1_i & (RS1addr_i == ID_EX_RDaddr_i)) |
                     (useRS2_i & (RS2addr_i == ID_EX_RDaddr_i)));
  assign in_err   = (state == ERROR);

  // Priority: freeze > flush > load-use stall.
  assign freeze_rule = in_err | memstall;
  assign flush_rule  = ~freeze_rule & branch_taken_i;
  assign lu_rule     = ~freeze_rule & ~branch_taken_i & loaduse;
  assign to_err      = ~in_err & memstall & (wait_cnt == WC_LAST);

  always_comb begin
    hazard_o     = 1'b0;
    PCWrite_o    = 1'b1;
    IF_IDWrite_o = 1'b1;
    IF_Flush_o   = 1'b0;
    freeze_o     = 1'b0;
    if (rst_i) begin
      hazard_o     = 1'b1;
      PCWrite_o    = 1'b0;
      IF_IDWrite_o = 1'b0;
    end else if (freeze_rule) begin
      freeze_o     = 1'b1;
      PCWrite_o    = 1'b0;
      IF_IDWrite_o = 1'b0;
    end else if (flush_rule) begin
      IF_Flush_o   = 1'b1;
      hazard_o     = 1'b1;
    end else if (lu_rule) begin
      hazard_o     = 1'b1;
      PCWrite_o    = 1'b0;
      IF_IDWrite_o = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    if (to_err) begin
      state_nxt = ERROR;
    end else begin
      case (state)
        RUN:      if (memstall) state_nxt = MEM_WAIT;
        MEM_WAIT: if (dmem_ready_i) state_nxt = RUN;
        ERROR:    state_nxt = ERROR;
        default:  state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_err_o   <= 1'b0;
      stall_cnt_o <= 16'd0;
      flush_cnt_o <= 16'd0;
    end else begin
      state <= state_nxt;
      // In ERROR the watchdog is irrelevant, so it simply holds.
      if (!in_err) begin
        if (memstall) wait_cnt <= wait_cnt + 1'b1;
        else          wait_cnt <= '0;
      end
      if (to_err) mem_err_o <= 1'b1;
      if (((memstall & ~in_err) | lu_rule) && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
      if (flush_rule && (flush_cnt_o != 16'hFFFF))
        flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the RV32I 5-stage core. It sits between the IF_ID register and the ID-stage control mux and drives `hazard_o` into that mux to turn the ID instruction into a bubble. It also gates PC and IF_ID writes, flushes IF on taken branches, and freezes the whole pipeline while data memory is not ready. A watchdog latches a sticky error on memory timeout, and saturating counters record stall and flush cycles.

## Interface
- `MEM_TIMEOUT`, default 64: number of consecutive freeze cycles that trips the watchdog. Must be ≥1.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `RS1addr_i`  in  5  rs1 field of the instruction in IF_ID.
- `RS2addr_i`  in  5  rs2 field of the instruction in IF_ID.
- `useRS1_i`  in  1  ID instruction reads rs1 (from Control).
- `useRS2_i`  in  1  ID instruction reads rs2 (from Control).
- `ID_EX_MemRead_i`  in  1  instruction in EX is a load.
- `ID_EX_RDaddr_i`  in  5  rd of the instruction in EX.
- `branch_taken_i`  in  1  EX resolved a taken branch or jump.
- `dmem_req_i`  in  1  MEM stage has an active data-memory access.
- `dmem_ready_i`  in  1  data memory completes the access this cycle.
- `hazard_o`  out  1  to the control mux: 1 forces a bubble into ID_EX.
- `PCWrite_o`  out  1  PC register write enable.
- `IF_IDWrite_o`  out  1  IF_ID register write enable.
- `IF_Flush_o`  out  1  zeroes IF_ID on the next edge.
- `freeze_o`  out  1  holds ID_EX, EX_MEM and MEM_WB.
- `mem_err_o`  out  1  sticky memory-timeout error.
- `stall_cnt_o`  out  16  saturating count of stall cycles.
- `flush_cnt_o`  out  16  saturating count of flush cycles.

## Operation
- States:
  - RUN: normal operation.
  - MEM_WAIT: a memory access is outstanding.
  - ERROR: terminal until reset.
- Derived condition `memstall` = `dmem_req_i` & ~`dmem_ready_i`.
- Derived condition `loaduse` = `ID_EX_MemRead_i` & (`ID_EX_RDaddr_i` ≠ 0) & ((`useRS1_i` & `RS1addr_i`==`ID_EX_RDaddr_i`) | (`useRS2_i` & `RS2addr_i`==`ID_EX_RDaddr_i`)).
- Outputs are Mealy (combinational from state and inputs). Evaluate in this priority order, first match wins:
  1. ERROR, or `memstall` in RUN or MEM_WAIT: `freeze_o`=1, `PCWrite_o`=0, `IF_IDWrite_o`=0, `hazard_o`=0, `IF_Flush_o`=0.
  2. `branch_taken_i`: `IF_Flush_o`=1, `hazard_o`=1, `PCWrite_o`=1, `IF_IDWrite_o`=1, `freeze_o`=0.
  3. `loaduse`: `hazard_o`=1, `PCWrite_o`=0, `IF_IDWrite_o`=0, `IF_Flush_o`=0, `freeze_o`=0.
  4. Otherwise: `PCWrite_o`=1, `IF_IDWrite_o`=1, all other outputs 0.
- State transitions:
  - RUN → MEM_WAIT on `memstall`.
  - MEM_WAIT → RUN when `dmem_ready_i`=1. That cycle is not a freeze; rules 2–4 apply.
  - RUN or MEM_WAIT → ERROR on a freeze cycle where `wait_cnt` == `MEM_TIMEOUT`-1.
  - ERROR has no exit except reset.
- Watchdog counter `wait_cnt`, width clog2(`MEM_TIMEOUT`+1):
  - +1 on each rule-1 freeze cycle outside ERROR.
  - Cleared on any non-freeze cycle.
- `mem_err_o` is set on entry to ERROR and cleared only by `rst_i`.
- `stall_cnt_o` +1 on each rule-1 cycle outside ERROR and on each rule-3 cycle. Saturates at 0xFFFF.
- `flush_cnt_o` +1 on each rule-2 cycle. Saturates at 0xFFFF.
- Simultaneous events:
  - `memstall` with `branch_taken_i` or `loaduse`: freeze wins. The EX/ID inputs are held by the frozen pipeline and get re-evaluated when the freeze lifts.
  - `branch_taken_i` with `loaduse`: flush wins. The ID instruction is discarded, so no stall is needed.

## Timing
- While `rst_i`=1 (combinational override):
  - `hazard_o`=1, `PCWrite_o`=0, `IF_IDWrite_o`=0, `IF_Flush_o`=0, `freeze_o`=0.
- At the first edge with `rst_i`=1:
  - state=RUN, `wait_cnt`=0, `mem_err_o`=0, `stall_cnt_o`=0, `flush_cnt_o`=0.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN at the next edge.
- Control outputs have zero latency (same cycle as inputs).
- Counters and `mem_err_o` update at the edge following the qualifying cycle.
- A load-use hazard gives exactly 1 bubble: next cycle the bubble sits in EX with `ID_EX_MemRead_i`=0, so `loaduse` clears.
- Watchdog: with `memstall` held from cycle 0, `mem_err_o` reads 1 after edge `MEM_TIMEOUT`. `ready` in cycle `MEM_TIMEOUT`-1 avoids the error.

## Test plan
- Load-use: EX `lw x5` (`ID_EX_MemRead_i`=1, rd=5), ID `add x6,x5,x1` (`useRS1_i`=1, rs1=5) → 1 cycle with `hazard_o`=1, `PCWrite_o`=0, `IF_IDWrite_o`=0. Then the condition clears and `stall_cnt_o`=1.
- No false stall:
  - rd=0 with rs1=0 → no stall.
  - rs2 match with `useRS2_i`=0 (e.g. addi) → no stall, `hazard_o`=0.
- Branch flush: `branch_taken_i`=1 together with a load-use match → `IF_Flush_o`=1, `hazard_o`=1, `PCWrite_o`=1. `flush_cnt_o`=1, `stall_cnt_o` unchanged.
- Memory wait: `dmem_req_i`=1, `ready` low for 3 cycles then high, `MEM_TIMEOUT`=64 → `freeze_o`=1 for 3 cycles, `branch_taken_i` held is ignored, then flush on the 4th cycle. `stall_cnt_o`=3, `mem_err_o`=0.
- Timeout: `MEM_TIMEOUT`=4, `memstall` held → `mem_err_o`=1 after the 4th edge. `freeze_o` stays 1 even after `dmem_ready_i`=1. `rst_i` pulse → `mem_err_o`=0, all counters 0.
- Saturation: force 70000 load-use cycles → `stall_cnt_o` holds 0xFFFF with no wrap.
